jump_encoder: RTL
=================

JUMP_ENCODER -- requirements
Module: jump_encoder

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the error counter.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-004 Port flush, input, 1, SHALL be the synchronous discard of all buffered results.
REQ-005 Port in_valid, input, 1, SHALL flag a request on in_pc/in_target/in_link.
REQ-006 Port in_ready, output, 1, SHALL flag that the block can accept a request this cycle.
REQ-007 Port in_pc, input, 32, SHALL carry the address of the jump instruction.
REQ-008 Port in_target, input, 32, SHALL carry the desired jump target address.
REQ-009 Port in_link, input, 1, SHALL select the opcode: 0 = j (000010), 1 = jal (000011).
REQ-010 Port out_valid, output, 1, SHALL flag a valid result at the buffer head.
REQ-011 Port out_ready, input, 1, SHALL flag that the consumer takes the head result this cycle.
REQ-012 Port out_instr, output, 32, SHALL carry the encoded J-type instruction word.
REQ-013 Port out_err, output, 2, SHALL carry the error flags: bit0 = misaligned, bit1 = region mismatch.
REQ-014 Port err_cnt, output, CNT_W, SHALL count accepted requests that had any error.

Function
REQ-015 Region SHALL be (in_pc + 32'd4)[31:28], i.e. the delay-slot address; the add wraps modulo 2^32.
REQ-016 The misaligned flag SHALL be set when in_target[1:0] != 2'b00.
REQ-017 The region-mismatch flag SHALL be set when in_target[31:28] != region.
REQ-018 With no error, out_instr SHALL be {opcode, in_target[27:2]}.
REQ-019 With any error, out_instr SHALL be 32'h0000_0000 (nop), and both flags are reported independently.
REQ-020 Encoding SHALL be combinational at acceptance, storing {instr, err} in a 2-entry FIFO.
REQ-021 A request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-022 A result accepted at edge N SHALL make out_valid high from edge N onward; minimum latency is 1 cycle.
REQ-023 A result SHALL pop on an edge where out_valid && out_ready; results leave in acceptance order.
REQ-024 in_ready SHALL equal (count != 2) and SHALL NOT depend combinationally on out_ready.
REQ-025 When full and popping, no push SHALL occur in that cycle.
REQ-026 Simultaneous push and pop with count == 1 SHALL leave count == 1, with the head replaced by the new entry.
REQ-027 out_valid SHALL be (count != 0); out_instr and out_err SHALL show the head entry, or 0 when empty.
REQ-028 On an edge with flush high, count SHALL become 0; flush overrides any push or pop on that edge; err_cnt is unaffected.
REQ-029 err_cnt SHALL increment by 1 per accepted erroneous request, at acceptance time, and saturate at all-ones.
REQ-030 During flush, an erroneous request SHALL NOT be counted, because it is not accepted.

Reset
REQ-031 While rst_n is low, asynchronously: count = 0, the FIFO pointers = 0, err_cnt = 0.
REQ-032 While rst_n is low, the outputs SHALL be: out_valid = 0, in_ready = 0, out_instr = 0, out_err = 0.
REQ-033 Reset mid-operation SHALL drop all buffered results.
REQ-034 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge.

Structure
REQ-035 Opcode constants (OP_J = 6'b000010, OP_JAL = 6'b000011) and error-bit indices SHALL live in the shared mips_defs package.
REQ-036 The FIFO SHALL be a sub-module named jenc_fifo2 (width 34, depth 2, with flush); the encoder logic stays in jump_encoder.

Verification
REQ-037 Basic j: in_pc=0x0040_0000, in_target=0x0040_0010, in_link=0 -> out_instr=0x0810_0004, out_err=00, out_valid 1 cycle later.
REQ-038 Basic jal: the same stimulus with in_link=1 -> out_instr=0x0C10_0004, out_err=00.
REQ-039 Misaligned target: in_target=0x0040_0012 -> out_instr=0, out_err=01, err_cnt=1.
REQ-040 Region boundary at the wrap: in_pc=0x0FFF_FFFC, target=0x1000_0000 -> 0x0800_0000, err=00; in_pc=0x0FFF_FFF8 with the same target -> err=10, err_cnt increments.
REQ-041 Backpressure: out_ready=0 with 3 back-to-back requests A, B, C -> in_ready drops after B and C is held. Then out_ready=1 -> A, B, C emerge in order, with no loss or duplication.
REQ-042 Flush and reset: flush with 2 entries plus a concurrent push -> count=0 and out_valid=0 next cycle, err_cnt unchanged. rst_n pulsed low mid-stream -> all outputs 0 immediately and err_cnt=0.

Source files
------------

// File: rtl/jump_encoder_pkg.sv
// Shared MIPS definitions: J-type opcodes, error-bit positions and the jump encoder.
package mips_defs;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_REGION   = 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err;
  } jenc_entry_t;

  localparam int JENC_ENTRY_W = $bits(jenc_entry_t);

  // The reachable 256 MB region comes from the delay-slot address, so pc+4 may cross into the next one.
  function automatic jenc_entry_t jenc_encode(input logic [31:0] pc,
                                              input logic [31:0] target,
                                              input logic        link);
    jenc_entry_t e;
    logic [3:0]  region;
    region                = 4'((pc + 32'd4) >> 28);
    e.err                 = '0;
    e.err[ERR_MISALIGN]   = (target[1:0] != 2'b00);
    e.err[ERR_REGION]     = (target[31:28] != region);
    e.instr               = (e.err == 2'b00) ? {(link ? OP_JAL : OP_J), target[27:2]} : 32'h0000_0000;
    return e;
  endfunction

endpackage

// File: rtl/jump_encoder_if.sv
// Request/result handshake bundle of the jump encoder; slave is the encoder side.
interface jump_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic        in_link;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_err;

  modport slave (
    input  in_valid, in_pc, in_target, in_link, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

  modport master (
    output in_valid, in_pc, in_target, in_link, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

endinterface

// File: rtl/jenc_fifo2.sv
// Two-entry FIFO with synchronous flush; data visible at head one edge after push.
// Push is ignored when full, pop ignored when empty; flush overrides both.
module jenc_fifo2 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);

  logic [1:0]   count;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [W-1:0] mem [2];
  logic         push_ok;
  logic         pop_ok;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      // With one entry, push+pop keeps count at 1 and the new entry becomes head.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jump_encoder.sv
// Encodes j/jal into a J-type word (nop on error) and buffers {instr, err}; result valid one edge after accept.
// in_ready drops only when both buffer entries are held, independent of out_ready; flush discards everything.
module jump_encoder
  import mips_defs::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  jump_encoder_if.slave    bus,
  output logic [CNT_W-1:0] err_cnt
);

  jenc_entry_t enc;
  jenc_entry_t head;
  logic        ready_q;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign enc = jenc_encode(bus.in_pc, bus.in_target, bus.in_link);

  // ready_q keeps in_ready low while in reset and raises it on the first edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign bus.in_ready  = ready_q && !full;
  assign push          = bus.in_valid && bus.in_ready && !flush;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !empty;
  assign bus.out_instr = head.instr;
  assign bus.out_err   = head.err;

  jenc_fifo2 #(
    .W (JENC_ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .push_dat (enc),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head_dat (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (push && (enc.err != 2'b00) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
